// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM states, op codes and
// default sizing (op codes match the multiplier's op input).
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_WIDTH = $clog2(DIV_WIDTH + 1);

  localparam logic OP_DIVU = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_FIXUP  = 2'd2,
    ST_DONE   = 2'd3
  } div_state_t;

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider for MIPS DIV/DIVU: one quotient bit per clock on
// operand magnitudes, sign fix-up in a final cycle; quotient on lo, remainder on hi.
module div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] abs_b_q, abs_b_d;
  logic [WIDTH-1:0] orig_a_q, orig_a_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             a_neg;
  logic             b_neg;

  assign a_neg = (op == OP_DIV) && opA[WIDTH-1];
  assign b_neg = (op == OP_DIV) && opB[WIDTH-1];

  // Trial subtract is one bit wider than the operands; its top bit is the borrow.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, abs_b_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    abs_b_d   = abs_b_q;
    orig_a_d  = orig_a_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    busy_d    = busy_q;
    done_d    = done_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        done_d = 1'b0;
        if (start) begin
          rem_d     = '0;
          quo_d     = a_neg ? -opA : opA;
          abs_b_d   = b_neg ? -opB : opB;
          orig_a_d  = opA;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = (opB == '0);
          cnt_d     = CW'(WIDTH);
          busy_d    = 1'b1;
          state_d   = ST_DIVIDE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DIVIDE: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        // A zero divisor reports all-ones quotient and passes the dividend through.
        lo_d    = div0_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
        hi_d    = div0_q ? orig_a_q : (neg_rem_q ? -rem_q : rem_q);
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      abs_b_q   <= '0;
      orig_a_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      abs_b_q   <= abs_b_d;
      orig_a_q  <= orig_a_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
